ldb_allocator: RTL and testbench

LDB_ALLOCATOR -- requirements
Module: ldb_allocator

---
 rtl/ldb_allocator.sv | 123 ++++++++++++
 tb/tb_ldb_allocator.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldb_allocator.sv
// Load-buffer entry allocator: two in-order allocation ports, per-entry release, flush.
// Optional macro LDB_RR_ALLOC_EN adds a round-robin search-start pointer (default: lowest free index first).
module ldb_allocator #(
    parameter int unsigned LDB_DEPTH = 16,
    parameter int unsigned LDB_IDX_W = $clog2(LDB_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_req0,
    input  logic                 alloc_req1,
    output logic                 alloc_gnt0,
    output logic                 alloc_gnt1,
    output logic [LDB_IDX_W-1:0] alloc_idx0,
    output logic [LDB_IDX_W-1:0] alloc_idx1,
    input  logic [LDB_DEPTH-1:0] release_vec,
    input  logic                 flush,
    output logic [LDB_DEPTH-1:0] entry_valid,
    output logic [LDB_IDX_W:0]   free_cnt,
    output logic                 full,
    output logic                 empty
);

    localparam int unsigned CNT_W = LDB_IDX_W + 1;

    logic [LDB_DEPTH-1:0] valid_q;
    logic [LDB_DEPTH-1:0] valid_d;
    logic [LDB_DEPTH-1:0] free_vec;
    logic [LDB_DEPTH-1:0] alloc_oh;
    logic [LDB_IDX_W-1:0] search_start;
    logic [LDB_IDX_W-1:0] scan_idx;
    logic [LDB_IDX_W-1:0] c0_idx;
    logic [LDB_IDX_W-1:0] c1_idx;
    logic                 c0_found;
    logic                 c1_found;
    logic                 gnt0;
    logic                 gnt1;
    logic [CNT_W-1:0]     cnt;

    assign free_vec = ~valid_q;

    // First and second free entries, scanning upward from search_start with wrap.
    always_comb begin
        c0_found = 1'b0;
        c1_found = 1'b0;
        c0_idx   = '0;
        c1_idx   = '0;
        scan_idx = '0;
        for (int unsigned i = 0; i < LDB_DEPTH; i++) begin
            scan_idx = search_start + LDB_IDX_W'(i);
            if (free_vec[scan_idx]) begin
                if (!c0_found) begin
                    c0_found = 1'b1;
                    c0_idx   = scan_idx;
                end else if (!c1_found) begin
                    c1_found = 1'b1;
                    c1_idx   = scan_idx;
                end
            end
        end
    end

    // Port 1 can only be granted alongside port 0 to keep allocation in program order.
    assign gnt0 = alloc_req0 & c0_found & ~flush & ~rst;
    assign gnt1 = alloc_req1 & gnt0 & c1_found;

    assign alloc_gnt0 = gnt0;
    assign alloc_gnt1 = gnt1;
    assign alloc_idx0 = gnt0 ? c0_idx : '0;
    assign alloc_idx1 = gnt1 ? c1_idx : '0;

    always_comb begin
        alloc_oh = '0;
        if (gnt0) alloc_oh = alloc_oh | (LDB_DEPTH'(1) << c0_idx);
        if (gnt1) alloc_oh = alloc_oh | (LDB_DEPTH'(1) << c1_idx);
    end

    // Releases of already-free entries fall out of the mask; granted entries are always free.
    always_comb begin
        valid_d = (valid_q & ~release_vec) | alloc_oh;
        if (flush) valid_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end

    assign entry_valid = valid_q;

    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < LDB_DEPTH; i++) begin
            cnt = cnt + CNT_W'(free_vec[i]);
        end
    end

    assign free_cnt = cnt;
    assign full     = (cnt == '0);
    assign empty    = (cnt == CNT_W'(LDB_DEPTH));

`ifdef LDB_RR_ALLOC_EN
    logic [LDB_IDX_W-1:0] rr_ptr_q;
    logic [LDB_IDX_W-1:0] rr_ptr_d;

    // Next search starts just past the youngest entry granted this cycle.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (flush)     rr_ptr_d = '0;
        else if (gnt1) rr_ptr_d = c1_idx + LDB_IDX_W'(1);
        else if (gnt0) rr_ptr_d = c0_idx + LDB_IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end

    assign search_start = rr_ptr_q;
`else
    assign search_start = '0;
`endif

endmodule

// File: tb/tb_ldb_allocator.sv
// Directed self-checking bench for ldb_allocator at the default 16-entry depth.
module tb_ldb_allocator;

    logic        clk;
    logic        rst;
    logic        alloc_req0;
    logic        alloc_req1;
    logic        alloc_gnt0;
    logic        alloc_gnt1;
    logic [3:0]  alloc_idx0;
    logic [3:0]  alloc_idx1;
    logic [15:0] release_vec;
    logic        flush;
    logic [15:0] entry_valid;
    logic [4:0]  free_cnt;
    logic        full;
    logic        empty;

    int tests_run;
    int tests_failed;

    ldb_allocator dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_req0  (alloc_req0),
        .alloc_req1  (alloc_req1),
        .alloc_gnt0  (alloc_gnt0),
        .alloc_gnt1  (alloc_gnt1),
        .alloc_idx0  (alloc_idx0),
        .alloc_idx1  (alloc_idx1),
        .release_vec (release_vec),
        .flush       (flush),
        .entry_valid (entry_valid),
        .free_cnt    (free_cnt),
        .full        (full),
        .empty       (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_req0  = 1'b0;
        alloc_req1  = 1'b0;
        release_vec = 16'h0000;
        flush       = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; alloc_req0 = 1'b1; alloc_req1 = 1'b1;
        #1;
        tests_run++;
        if (alloc_gnt0 !== 1'b0 || alloc_gnt1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_comb_gnt: got gnt0=%b gnt1=%b, want 0 0", alloc_gnt0, alloc_gnt1);
        end
        tick(); tick();
        rst = 1'b0; idle();
        #1;
        tests_run++;
        if (entry_valid !== 16'h0000 || free_cnt !== 5'd16 || full !== 1'b0 || empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_state: got valid=%h cnt=%0d full=%b empty=%b, want 0000 16 0 1",
                     entry_valid, free_cnt, full, empty);
        end
        tests_run++;
        if (alloc_gnt0 !== 1'b0 || alloc_gnt1 !== 1'b0 || alloc_idx0 !== 4'd0 || alloc_idx1 !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got gnt=%b%b idx0=%0d idx1=%0d, want 00 0 0",
                     alloc_gnt0, alloc_gnt1, alloc_idx0, alloc_idx1);
        end
    endtask

    task automatic test_req1_alone();
        idle(); alloc_req1 = 1'b1;
        #1;
        tests_run++;
        if (alloc_gnt0 !== 1'b0 || alloc_gnt1 !== 1'b0 || alloc_idx1 !== 4'd0) begin
            tests_failed++;
            $display("FAIL req1_alone: got gnt0=%b gnt1=%b idx1=%0d, want 0 0 0", alloc_gnt0, alloc_gnt1, alloc_idx1);
        end
        tick();
        idle();
        #1;
        tests_run++;
        if (entry_valid !== 16'h0000) begin
            tests_failed++;
            $display("FAIL req1_alone_state: got valid=%h, want 0000", entry_valid);
        end
    endtask

    task automatic test_dual_alloc();
        idle(); alloc_req0 = 1'b1; alloc_req1 = 1'b1;
        #1;
        tests_run++;
        if (alloc_gnt0 !== 1'b1 || alloc_gnt1 !== 1'b1 || alloc_idx0 !== 4'd0 || alloc_idx1 !== 4'd1) begin
            tests_failed++;
            $display("FAIL dual_alloc: got gnt=%b%b idx0=%0d idx1=%0d, want 11 0 1",
                     alloc_gnt0, alloc_gnt1, alloc_idx0, alloc_idx1);
        end
        tests_run++;
        if (free_cnt !== 5'd16) begin
            tests_failed++;
            $display("FAIL dual_alloc_cnt_latency: got cnt=%0d, want 16", free_cnt);
        end
        tick();
        idle();
        #1;
        tests_run++;
        if (free_cnt !== 5'd14 || empty !== 1'b0 || entry_valid !== 16'h0003) begin
            tests_failed++;
            $display("FAIL dual_alloc_state: got cnt=%0d empty=%b valid=%h, want 14 0 0003",
                     free_cnt, empty, entry_valid);
        end
    endtask

    task automatic test_fill_full();
        for (int k = 0; k < 7; k++) begin
            idle(); alloc_req0 = 1'b1; alloc_req1 = 1'b1;
            #1;
            tests_run++;
            if (alloc_gnt0 !== 1'b1 || alloc_gnt1 !== 1'b1 ||
                alloc_idx0 !== 4'(2 + 2 * k) || alloc_idx1 !== 4'(3 + 2 * k)) begin
                tests_failed++;
                $display("FAIL fill_step%0d: got gnt=%b%b idx0=%0d idx1=%0d, want 11 %0d %0d",
                         k, alloc_gnt0, alloc_gnt1, alloc_idx0, alloc_idx1, 2 + 2 * k, 3 + 2 * k);
            end
            tick();
        end
        idle();
        #1;
        tests_run++;
        if (full !== 1'b1 || free_cnt !== 5'd0 || entry_valid !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL fill_full: got full=%b cnt=%0d valid=%h, want 1 0 ffff", full, free_cnt, entry_valid);
        end
        alloc_req0 = 1'b1;
        #1;
        tests_run++;
        if (alloc_gnt0 !== 1'b0 || alloc_idx0 !== 4'd0) begin
            tests_failed++;
            $display("FAIL full_no_grant: got gnt0=%b idx0=%0d, want 0 0", alloc_gnt0, alloc_idx0);
        end
        tick();
        idle(); release_vec = 16'h0020;
        #1;
        tests_run++;
        if (entry_valid !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL full_state_held: got valid=%h, want ffff", entry_valid);
        end
        tick();
        idle();
        #1;
        tests_run++;
        if (free_cnt !== 5'd1 || full !== 1'b0 || entry_valid !== 16'hFFDF) begin
            tests_failed++;
            $display("FAIL release5: got cnt=%0d full=%b valid=%h, want 1 0 ffdf", free_cnt, full, entry_valid);
        end
        alloc_req0 = 1'b1; alloc_req1 = 1'b1;
        #1;
        tests_run++;
        if (alloc_gnt0 !== 1'b1 || alloc_idx0 !== 4'd5 || alloc_gnt1 !== 1'b0 || alloc_idx1 !== 4'd0) begin
            tests_failed++;
            $display("FAIL one_free_dual_req: got gnt0=%b idx0=%0d gnt1=%b idx1=%0d, want 1 5 0 0",
                     alloc_gnt0, alloc_idx0, alloc_gnt1, alloc_idx1);
        end
        tick();
        idle();
        #1;
        tests_run++;
        if (full !== 1'b1 || entry_valid !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL refill: got full=%b valid=%h, want 1 ffff", full, entry_valid);
        end
    endtask

    task automatic test_release_same_cycle();
        idle(); release_vec = 16'h0008; alloc_req0 = 1'b1;
        #1;
        tests_run++;
        if (alloc_gnt0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL release_same_cycle: got gnt0=%b, want 0", alloc_gnt0);
        end
        tick();
        idle(); alloc_req0 = 1'b1;
        #1;
        tests_run++;
        if (alloc_gnt0 !== 1'b1 || alloc_idx0 !== 4'd3) begin
            tests_failed++;
            $display("FAIL release_next_cycle: got gnt0=%b idx0=%0d, want 1 3", alloc_gnt0, alloc_idx0);
        end
        tick();
        idle();
        #1;
        tests_run++;
        if (entry_valid !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL realloc3: got valid=%h, want ffff", entry_valid);
        end
    endtask

    task automatic test_flush();
        idle(); release_vec = 16'hFC00;
        tick();
        idle();
        #1;
        tests_run++;
        if (entry_valid !== 16'h03FF || free_cnt !== 5'd6) begin
            tests_failed++;
            $display("FAIL pre_flush: got valid=%h cnt=%0d, want 03ff 6", entry_valid, free_cnt);
        end
        flush = 1'b1; alloc_req0 = 1'b1; alloc_req1 = 1'b1;
        #1;
        tests_run++;
        if (alloc_gnt0 !== 1'b0 || alloc_gnt1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_grant: got gnt0=%b gnt1=%b, want 0 0", alloc_gnt0, alloc_gnt1);
        end
        tick();
        idle();
        #1;
        tests_run++;
        if (entry_valid !== 16'h0000 || empty !== 1'b1 || free_cnt !== 5'd16) begin
            tests_failed++;
            $display("FAIL flush_state: got valid=%h empty=%b cnt=%0d, want 0000 1 16", entry_valid, empty, free_cnt);
        end
    endtask

    task automatic test_search_start();
        logic [3:0]  exp_idx;
        logic [3:0]  exp_idx2;
        logic [15:0] held;
        idle(); alloc_req0 = 1'b1; alloc_req1 = 1'b1;
        #1;
        tests_run++;
        if (alloc_idx0 !== 4'd0 || alloc_idx1 !== 4'd1 || alloc_gnt1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL rr_first_pair: got idx0=%0d idx1=%0d gnt1=%b, want 0 1 1", alloc_idx0, alloc_idx1, alloc_gnt1);
        end
        tick();
        idle(); release_vec = 16'h0003;
        tick();
`ifdef LDB_RR_ALLOC_EN
        exp_idx  = 4'd2;
        exp_idx2 = 4'd3;
`else
        exp_idx  = 4'd0;
        exp_idx2 = 4'd1;
`endif
        idle(); alloc_req0 = 1'b1;
        #1;
        tests_run++;
        if (alloc_gnt0 !== 1'b1 || alloc_idx0 !== exp_idx) begin
            tests_failed++;
            $display("FAIL search_start: got gnt0=%b idx0=%0d, want 1 %0d", alloc_gnt0, alloc_idx0, exp_idx);
        end
        tick();
        held = 16'h0001 << exp_idx;
        idle(); release_vec = ~held; alloc_req0 = 1'b1;
        #1;
        tests_run++;
        if (alloc_gnt0 !== 1'b1 || alloc_idx0 !== exp_idx2) begin
            tests_failed++;
            $display("FAIL release_free_bits_grant: got gnt0=%b idx0=%0d, want 1 %0d", alloc_gnt0, alloc_idx0, exp_idx2);
        end
        tick();
        idle();
        #1;
        tests_run++;
        if (entry_valid !== (held | (16'h0001 << exp_idx2))) begin
            tests_failed++;
            $display("FAIL release_free_bits_state: got valid=%h, want %h", entry_valid, held | (16'h0001 << exp_idx2));
        end
    endtask

    task automatic test_reset_mid();
        idle(); alloc_req0 = 1'b1; alloc_req1 = 1'b1;
        tick();
        idle(); rst = 1'b1; alloc_req0 = 1'b1; alloc_req1 = 1'b1; flush = 1'b1; release_vec = 16'h00F0;
        #1;
        tests_run++;
        if (alloc_gnt0 !== 1'b0 || alloc_gnt1 !== 1'b0 || entry_valid === 16'h0000) begin
            tests_failed++;
            $display("FAIL rst_mid_grant: got gnt0=%b gnt1=%b valid=%h, want 0 0 nonzero",
                     alloc_gnt0, alloc_gnt1, entry_valid);
        end
        tick();
        rst = 1'b0; idle();
        #1;
        tests_run++;
        if (entry_valid !== 16'h0000 || free_cnt !== 5'd16 || empty !== 1'b1 || full !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_state: got valid=%h cnt=%0d empty=%b full=%b, want 0000 16 1 0",
                     entry_valid, free_cnt, empty, full);
        end
        alloc_req0 = 1'b1;
        #1;
        tests_run++;
        if (alloc_gnt0 !== 1'b1 || alloc_idx0 !== 4'd0) begin
            tests_failed++;
            $display("FAIL rst_search_start: got gnt0=%b idx0=%0d, want 1 0", alloc_gnt0, alloc_idx0);
        end
        tick();
        idle();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        idle();
        test_reset();
        test_req1_alone();
        test_dual_alloc();
        test_fill_full();
        test_release_same_cycle();
        test_flush();
        test_search_start();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
